instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width of the instruction memory write port (256 bytes).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the word counter.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first byte address of the load; sampled with start.
REQ-008 word_count  input  CNT_W  number of 16-bit words to load; sampled with start.
REQ-009 in_valid  input  1  source presents an instruction word.
REQ-010 in_data  input  16  instruction word, bits [15:8] = first-fetched byte.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 wr_en  output  1  byte write strobe to instruction memory.
REQ-013 wr_addr  output  ADDR_W  byte address of the write.
REQ-014 wr_data  output  8  byte written.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a load.
REQ-017 words_written  output  CNT_W  words completed in the current or most recent load.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ACCEPT, WR_HI, WR_LO and DONE.
REQ-019 In IDLE with start=1, the FSM SHALL latch base_addr into the address register, latch word_count into the remaining-word counter and clear words_written.
REQ-020 From IDLE with start=1, the FSM SHALL go to DONE if word_count=0, else to ACCEPT.
REQ-021 In ACCEPT, in_ready SHALL be 1; in every other state, in_ready SHALL be 0.
REQ-022 In ACCEPT, a transfer SHALL occur only in a cycle where in_valid=1 and in_ready=1; on a transfer, the FSM SHALL capture in_data and go to WR_HI.
REQ-023 In ACCEPT with in_valid=0, the FSM SHALL remain in ACCEPT indefinitely.
REQ-024 In WR_HI, the outputs SHALL be wr_en=1, wr_addr=address register and wr_data=captured[15:8]; next state SHALL be WR_LO.
REQ-025 In WR_LO, the outputs SHALL be wr_en=1, wr_addr=(address register+1) mod 2^ADDR_W and wr_data=captured[7:0] (big-endian, matching the fetch order {Mem[a],Mem[a+1]}).
REQ-026 In WR_LO, the block SHALL:
  - advance the address register by 2, mod 2^ADDR_W;
  - decrement the remaining-word counter;
  - increment words_written;
  - go to DONE if the remaining count becomes 0, else to ACCEPT.
REQ-027 In IDLE, ACCEPT and DONE, wr_en SHALL be 0; in those states, wr_addr and wr_data SHALL hold their last values.
REQ-028 In DONE, done SHALL be 1 for exactly one cycle; next state SHALL be IDLE.
REQ-029 Latency: a word accepted in cycle N SHALL be written as its high byte in N+1 and its low byte in N+2; in_ready SHALL be high again no earlier than N+3.
REQ-030 Address wrap: the address SHALL wrap modulo 2^ADDR_W with no error indication; with base_addr=8'hFF, the high byte SHALL be written at 8'hFF and the low byte at 8'h00.
REQ-031 Odd base_addr values SHALL be legal and SHALL NOT be realigned.
REQ-032 start asserted while busy=1 SHALL be ignored and SHALL NOT alter any register.
REQ-033 words_written SHALL hold its value after DONE until the next accepted start.

Reset
REQ-034 While reset_n=0, the block SHALL asynchronously force:
  - state to IDLE;
  - in_ready, wr_en, busy and done to 0;
  - wr_addr, wr_data, words_written, the address register, the remaining counter and the captured word to 0.
REQ-035 Reset asserted mid-load (including during WR_HI or WR_LO) SHALL drop wr_en immediately, without waiting for a clock edge; the partially written word SHALL NOT be completed after reset releases.
REQ-036 After reset_n rises, the block SHALL remain in IDLE until a start is sampled.

Verification
REQ-037 The bench SHALL cover: start, base_addr=8'h00, word_count=2, words 16'h3112 then 16'h3413 with in_valid always 1 -> byte writes (00,31),(01,12),(02,34),(03,13); done pulses 1 cycle after the last write; words_written=2.
REQ-038 The bench SHALL cover: start with word_count=0 -> no wr_en; done pulses in the cycle after start; busy high for that one cycle; words_written=0.
REQ-039 The bench SHALL cover: base_addr=8'hFF, word_count=1, word 16'hABCD -> writes (FF,AB),(00,CD).
REQ-040 The bench SHALL cover: in_valid held low 5 cycles in ACCEPT -> in_ready stays 1, no wr_en, state held; the word is then accepted on the first in_valid cycle.
REQ-041 The bench SHALL cover: start pulsed while busy with a different base_addr -> the active load is unaffected and addresses continue from the original base.
REQ-042 The bench SHALL cover: reset_n asserted during WR_HI -> wr_en=0 with no clock edge; after release, IDLE, busy=0 and words_written=0.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: streams 16-bit words into a byte-wide instruction memory, high byte first
module instruction_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WR_HI, WR_LO, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr, last_addr;
  logic [CNT_W-1:0] remaining;
  logic [15:0] word;
  logic [7:0] last_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (word_count == '0) ? DONE : ACCEPT;
      ACCEPT:  if (in_valid) state_nx = WR_HI;
      WR_HI:   state_nx = WR_LO;
      WR_LO:   state_nx = (remaining == CNT_W'(1)) ? DONE : ACCEPT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Strobes decode straight from state so an async reset drops wr_en without a clock edge
  assign in_ready = state == ACCEPT;
  assign wr_en    = state == WR_HI || state == WR_LO;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign wr_addr  = state == WR_HI ? addr : state == WR_LO ? addr + ADDR_W'(1) : last_addr;
  assign wr_data  = state == WR_HI ? word[15:8] : state == WR_LO ? word[7:0] : last_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr          <= '0;
      remaining     <= '0;
      words_written <= '0;
      word          <= '0;
      last_addr     <= '0;
      last_data     <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr          <= base_addr;
        remaining     <= word_count;
        words_written <= '0;
      end
      if (state == ACCEPT && in_valid) word <= in_data;
      if (state == WR_LO) begin
        addr          <= addr + ADDR_W'(2);
        remaining     <= remaining - CNT_W'(1);
        words_written <= words_written + CNT_W'(1);
      end
      if (wr_en) begin
        last_addr <= wr_addr;
        last_data <= wr_data;
      end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: scoreboard bench; stimulus queues expected writes/done pulses, a negedge monitor checks them
module tb_instruction_loader;
  logic clk = 0, reset_n = 0, start = 0, in_valid = 0;
  logic [7:0] base_addr = 0, word_count = 0;
  logic [15:0] in_data = 0;
  logic in_ready, wr_en, busy, done;
  logic [7:0] wr_addr, wr_data, words_written;
  typedef struct {bit is_done; logic [7:0] a; logic [7:0] d; int gap;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [15:0] wq[$];
  int checks = 0, errors = 0, cyc = 0, last = 0;
  instruction_loader #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .words_written(words_written)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input int gap);
    sb.push_back('{0, a, d, gap});
  endtask
  task automatic push_done(input logic [7:0] ww, input int gap);
    sb.push_back('{1, 8'h00, ww, gap});
  endtask
  always @(negedge clk) if (reset_n) begin
    cyc++;
    if (wr_en) begin
      if (sb.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_kind", 32'(e.is_done), 0);
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        if (e.gap != 0) chk("wr_gap", cyc - last, e.gap);
        last = cyc;
      end
    end
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_kind", 32'(e.is_done), 1);
        chk("done_words", 32'(words_written), 32'(e.d));
        if (e.gap != 0) chk("done_gap", cyc - last, e.gap);
      end
    end
  end
  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask
  // mode 0: plain, 1: stall 5 cycles first, 2: start held high (other base) while busy
  task automatic run_load(input logic [7:0] b, input logic [7:0] n, input int mode);
    int k = 0;
    base_addr = b; word_count = n; start = 1;
    @(posedge clk); #1;
    start = (mode == 2); base_addr = 8'h80; word_count = 8'd5;
    if (mode == 1) begin
      in_valid = 0;
      repeat (5) begin
        @(posedge clk); #1;
        chk("stall_ready", 32'(in_ready), 1);
        chk("stall_no_wr", 32'(wr_en), 0);
      end
    end
    for (int i = 0; i < wq.size(); i++) begin
      in_data = wq[i]; in_valid = 1;
      wait_ready();
      @(posedge clk); #1;
    end
    start = 0; in_valid = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask
  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_words", 32'(words_written), 0);
    @(posedge clk); #1 reset_n = 1;
    repeat (2) @(posedge clk); #1;
    chk("idle_after_rst", 32'(busy), 0);
    push_wr(8'h00, 8'h31, 0); push_wr(8'h01, 8'h12, 1);
    push_wr(8'h02, 8'h34, 2); push_wr(8'h03, 8'h13, 1);
    push_done(8'd2, 1);
    wq = '{16'h3112, 16'h3413};
    run_load(8'h00, 8'd2, 0);
    repeat (3) @(posedge clk); #1;
    chk("words_hold", 32'(words_written), 2);
    chk("wr_addr_hold", 32'(wr_addr), 8'h03);
    chk("wr_data_hold", 32'(wr_data), 8'h13);
    push_done(8'd0, 0);
    base_addr = 8'h44; word_count = 8'd0; start = 1;
    @(posedge clk); #1 start = 0;
    chk("zero_busy", 32'(busy), 1);
    chk("zero_done", 32'(done), 1);
    chk("zero_ready", 32'(in_ready), 0);
    chk("zero_words", 32'(words_written), 0);
    @(posedge clk); #1;
    chk("zero_busy_end", 32'(busy), 0);
    chk("zero_done_end", 32'(done), 0);
    push_wr(8'hFF, 8'hAB, 0); push_wr(8'h00, 8'hCD, 1); push_done(8'd1, 1);
    wq = '{16'hABCD};
    run_load(8'hFF, 8'd1, 0);
    push_wr(8'h41, 8'h5A, 0); push_wr(8'h42, 8'h6B, 1); push_done(8'd1, 1);
    wq = '{16'h5A6B};
    run_load(8'h41, 8'd1, 1);
    push_wr(8'h10, 8'hC0, 0); push_wr(8'h11, 8'hDE, 1);
    push_wr(8'h12, 8'hBE, 2); push_wr(8'h13, 8'hEF, 1);
    push_done(8'd2, 1);
    wq = '{16'hC0DE, 16'hBEEF};
    run_load(8'h10, 8'd2, 2);
    chk("busy_start_words", 32'(words_written), 2);
    repeat (2) @(posedge clk); #1;
    chk("busy_start_idle", 32'(busy), 0);
    base_addr = 8'h20; word_count = 8'd1; start = 1;
    @(posedge clk); #1 start = 0;
    in_data = 16'h7788; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    chk("mid_wr_en", 32'(wr_en), 1);
    chk("mid_wr_addr", 32'(wr_addr), 8'h20);
    #2 reset_n = 0;
    #1;
    chk("async_wr_en", 32'(wr_en), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_ready", 32'(in_ready), 0);
    chk("async_words", 32'(words_written), 0);
    chk("async_wr_addr", 32'(wr_addr), 0);
    chk("async_wr_data", 32'(wr_data), 0);
    repeat (2) @(posedge clk); #1 reset_n = 1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_words", 32'(words_written), 0);
    chk("post_rst_wr_en", 32'(wr_en), 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
